// File: rtl/memory_responder.sv
// Word-addressed RAM responder for the MAR/MDR interface, with programmable wait states,
// a one-cycle mem_ready completion pulse and a sticky out-of-range flag.
module memory_responder #(
  parameter int unsigned ADDR_BITS   = 9,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  Clock,
  input  logic                  clear,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] Mdatain,
  output logic                  mem_ready,
  output logic                  busy,
  output logic                  addr_fault
);

  localparam int unsigned Depth = 1 << ADDR_BITS;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWait   = 3'd1;
  localparam logic [2:0] StAccess = 3'd2;
  localparam logic [2:0] StDone   = 3'd3;
  localparam logic [2:0] StHold   = 3'd4;

  // WAIT is left when the counter is zero, so load WAIT_STATES-1 to spend exactly
  // WAIT_STATES cycles there.
  localparam logic [3:0] WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [2:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]  addr_q;
  logic                  oor_q;
  logic                  is_write_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] mdat_q;
  logic                  fault_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  req;
  logic                  addr_oor;

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  assign req      = Read | Write;
  assign addr_oor = (address >> ADDR_BITS) != 32'd0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          state_d = (WAIT_STATES > 0) ? StWait : StAccess;
          cnt_d   = WaitLoad;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StAccess;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAccess: state_d = StDone;
      StDone:   state_d = StHold;
      StHold: begin
        if (!req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      oor_q      <= 1'b0;
      is_write_q <= 1'b0;
      data_q     <= '0;
      mdat_q     <= '0;
      fault_q    <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == StDone);
      busy_q  <= (state_d != StIdle);
      if (state_q == StIdle && req) begin
        addr_q     <= address[ADDR_BITS-1:0];
        oor_q      <= addr_oor;
        is_write_q <= Write;
        data_q     <= data_in;
      end
      if (state_q == StAccess) begin
        if (oor_q) begin
          fault_q <= 1'b1;
        end
        if (!is_write_q) begin
          mdat_q <= oor_q ? '0 : mem_q[addr_q];
        end
      end
    end
  end

  // Array is deliberately not reset; a clear before ACCESS leaves state IDLE, so no store.
  always_ff @(posedge Clock) begin
    if (state_q == StAccess && is_write_q && !oor_q) begin
      mem_q[addr_q] <= data_q;
    end
  end

  assign Mdatain    = mdat_q;
  assign mem_ready  = ready_q;
  assign busy       = busy_q;
  assign addr_fault = fault_q;

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench: three responders (0, 1 and 3 wait states) share one stimulus stream and are
// checked against a plain array model of the memory.
module tb_memory_responder;

  logic        Clock = 1'b0;
  logic        clear;
  logic        Read;
  logic        Write;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] mdat [3];
  logic        mr   [3];
  logic        bsy  [3];
  logic        flt  [3];

  memory_responder #(.ADDR_BITS(9), .DATA_WIDTH(32), .WAIT_STATES(0)) u_ws0 (
    .Clock(Clock), .clear(clear), .Read(Read), .Write(Write), .address(address),
    .data_in(data_in), .Mdatain(mdat[0]), .mem_ready(mr[0]), .busy(bsy[0]), .addr_fault(flt[0])
  );
  memory_responder #(.ADDR_BITS(9), .DATA_WIDTH(32), .WAIT_STATES(1)) u_ws1 (
    .Clock(Clock), .clear(clear), .Read(Read), .Write(Write), .address(address),
    .data_in(data_in), .Mdatain(mdat[1]), .mem_ready(mr[1]), .busy(bsy[1]), .addr_fault(flt[1])
  );
  memory_responder #(.ADDR_BITS(9), .DATA_WIDTH(32), .WAIT_STATES(3)) u_ws3 (
    .Clock(Clock), .clear(clear), .Read(Read), .Write(Write), .address(address),
    .data_in(data_in), .Mdatain(mdat[2]), .mem_ready(mr[2]), .busy(bsy[2]), .addr_fault(flt[2])
  );

  typedef struct {
    int unsigned req;
    logic [31:0] mdat;
    logic        fault;
  } exp_t;

  exp_t        exp_q [$];
  int unsigned rd_ptr [3];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  logic [31:0] ref_mem [512];
  logic [31:0] m_mdat;
  logic        m_fault;
  logic [31:0] pool [8];

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  function automatic int unsigned ws_of(input int k);
    case (k)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s dut%0d: got %h want %h (t=%0t)", name, k, act, want, $time);
    end
  endtask

  function automatic bit all_done();
    return rd_ptr[0] == exp_q.size() && rd_ptr[1] == exp_q.size() && rd_ptr[2] == exp_q.size();
  endfunction

  // Monitor: every mem_ready pulse consumes the next expected completion for that instance.
  // Sampled on the falling edge, so a pulse seen here is high at edge cyc+1.
  always @(negedge Clock) begin
    for (int k = 0; k < 3; k++) begin
      if (mr[k] === 1'b1) begin
        if (rd_ptr[k] >= exp_q.size()) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready dut%0d: got pulse want none (t=%0t)", k, $time);
        end else begin
          exp_t e;
          e = exp_q[rd_ptr[k]];
          rd_ptr[k]++;
          // mem_ready is high at the (WAIT_STATES+2)th edge after the request edge.
          check("latency", k, 32'(cyc + 1 - e.req), 32'(ws_of(k) + 2));
          check("mdatain", k, mdat[k], e.mdat);
          check("addr_fault", k, 32'(flt[k]), 32'(e.fault));
          check("busy_at_ready", k, 32'(bsy[k]), 32'd1);
        end
      end
    end
  end

  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d);
    exp_t e;
    bit   oor;
    Read    = rd;
    Write   = wr;
    address = a;
    data_in = d;
    oor     = (a >= 32'd512);
    if (wr) begin
      if (!oor) ref_mem[a[8:0]] = d;
    end else begin
      m_mdat = oor ? 32'd0 : ref_mem[a[8:0]];
    end
    if (oor) m_fault = 1'b1;
    e.req   = cyc + 1;
    e.mdat  = m_mdat;
    e.fault = m_fault;
    exp_q.push_back(e);
  endtask

  task automatic do_op(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input int hold_min);
    int n;
    @(posedge Clock); #1;
    issue(rd, wr, a, d);
    @(posedge Clock); #1;
    for (int k = 0; k < 3; k++) check("busy_on", k, 32'(bsy[k]), 32'd1);
    n = 1;
    // Address/data wander while the strobe is held; the latched request must win.
    while (!all_done() && n < 40) begin
      address = $urandom;
      data_in = $urandom;
      @(posedge Clock); #1;
      n++;
    end
    if (!all_done()) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got %0d/%0d/%0d want %0d completions",
               rd_ptr[0], rd_ptr[1], rd_ptr[2], exp_q.size());
      for (int k = 0; k < 3; k++) rd_ptr[k] = exp_q.size();
    end
    while (n < hold_min) begin
      address = $urandom;
      @(posedge Clock); #1;
      n++;
    end
    Read  = 1'b0;
    Write = 1'b0;
    @(posedge Clock); #1;
    for (int k = 0; k < 3; k++) check("busy_off", k, 32'(bsy[k]), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    for (int k = 0; k < 3; k++) begin
      check({name, "_mdatain"}, k, mdat[k], 32'd0);
      check({name, "_ready"}, k, 32'(mr[k]), 32'd0);
      check({name, "_busy"}, k, 32'(bsy[k]), 32'd0);
      check({name, "_fault"}, k, 32'(flt[k]), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          op;
    clear   = 1'b1;
    Read    = 1'b0;
    Write   = 1'b0;
    address = 32'd0;
    data_in = 32'd0;
    m_mdat  = 32'd0;
    m_fault = 1'b0;
    for (int k = 0; k < 3; k++) rd_ptr[k] = 0;
    pool[0] = 32'h000; pool[1] = 32'h010; pool[2] = 32'h020; pool[3] = 32'h054;
    pool[4] = 32'h063; pool[5] = 32'h0AA; pool[6] = 32'h100; pool[7] = 32'h1FF;

    repeat (3) @(posedge Clock);
    #1;
    check_all_zero("reset");
    clear = 1'b0;

    for (int i = 0; i < 8; i++) do_op(1'b0, 1'b1, pool[i], $urandom, 0);

    do_op(1'b0, 1'b1, 32'h54, 32'h0000_00A5, 0);
    do_op(1'b1, 1'b0, 32'h54, 32'h0, 0);
    do_op(1'b0, 1'b1, 32'h63, 32'h1234_5678, 0);
    do_op(1'b1, 1'b0, 32'h63, 32'h0, 0);
    do_op(1'b1, 1'b0, 32'h63, 32'h0, 10);
    do_op(1'b1, 1'b0, 32'h63, 32'h0, 0);
    do_op(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 0);
    do_op(1'b1, 1'b0, 32'h10, 32'h0, 0);
    do_op(1'b1, 1'b0, 32'h1FF, 32'h0, 0);
    do_op(1'b1, 1'b0, 32'h200, 32'h0, 0);
    do_op(1'b0, 1'b1, 32'h200, 32'hCAFE_F00D, 0);
    do_op(1'b1, 1'b0, 32'h000, 32'h0, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom | (32'h1 << $urandom_range(9, 31));
      else a = pool[$urandom_range(0, 7)];
      op = $urandom_range(0, 2);
      do_op(op != 1, op != 0, a, $urandom, $urandom_range(0, 3));
    end

    // Clear during WAIT (ACCESS for the zero-wait instance) aborts the store.
    do_op(1'b0, 1'b1, 32'h63, 32'h7777_0001, 0);
    do_op(1'b1, 1'b0, 32'h63, 32'h0, 0);
    do_op(1'b0, 1'b1, 32'h20, 32'h0000_0011, 0);
    @(posedge Clock); #1;
    Write   = 1'b1;
    address = 32'h20;
    data_in = 32'hFFFF_FFFF;
    @(posedge Clock); #1;
    for (int k = 0; k < 3; k++) check("busy_pre_clear", k, 32'(bsy[k]), 32'd1);
    #1;
    clear = 1'b1;
    #1;
    check_all_zero("async_clear");
    @(posedge Clock); #1;
    Write   = 1'b0;
    clear   = 1'b0;
    m_mdat  = 32'd0;
    m_fault = 1'b0;
    do_op(1'b1, 1'b0, 32'h20, 32'h0, 0);

    for (int i = 0; i < 8; i++) begin
      op = $urandom_range(0, 2);
      do_op(op != 1, op != 0, pool[$urandom_range(0, 7)], $urandom, $urandom_range(0, 2));
    end

    repeat (3) @(posedge Clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
